// File: rtl/team_06_bridge_pkg.sv
// Shared register map, STATUS/IRQ bit positions and register selector for the
// Wishbone-to-stream FIFO bridge.
package team_06_bridge_pkg;

    typedef enum logic [1:0] {
        RegData    = 2'd0,
        RegStatus  = 2'd1,
        RegIrqEn   = 2'd2,
        RegIrqStat = 2'd3
    } reg_sel_e;

    localparam logic [3:0] OffData    = 4'h0;
    localparam logic [3:0] OffStatus  = 4'h4;
    localparam logic [3:0] OffIrqEn   = 4'h8;
    localparam logic [3:0] OffIrqStat = 4'hC;

    localparam int unsigned StatTxFull  = 0;
    localparam int unsigned StatTxEmpty = 1;
    localparam int unsigned StatRxFull  = 2;
    localparam int unsigned StatRxEmpty = 3;
    localparam int unsigned StatTxCount = 8;
    localparam int unsigned StatRxCount = 16;

    localparam int unsigned IrqRxNonempty = 0;
    localparam int unsigned IrqTxEmpty    = 1;
    localparam int unsigned IrqTxOvf      = 2;
    localparam int unsigned IrqRxUnf      = 3;

    function automatic reg_sel_e decode_reg(input logic [3:0] offset);
        return reg_sel_e'(offset[3:2]);
    endfunction

endpackage

// File: rtl/team_06_sync_fifo.sv
// Single-clock FIFO with natural-wrap pointers and an explicit occupancy count.
module team_06_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    // A push into a full FIFO is only safe when a pop frees a slot in the same cycle.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/team_06_wb_fifo_bridge.sv
// Wishbone slave bridging a TX and an RX stream FIFO to the bus; interrupt
// registers and irq_o exist only when TEAM_06_BRIDGE_IRQ_EN is defined.
module team_06_wb_fifo_bridge
    import team_06_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DEPTH     = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        irq_o,
    output logic [31:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [31:0] rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    reg_sel_e      reg_sel;
    logic          accept, hit, bus_wr, bus_rd;
    logic          tx_push, tx_pop, rx_push, rx_pop, tx_ovf_evt, rx_unf_evt;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic [31:0]   rx_rdata, status;
    logic [3:0]    irq_en, irq_stat;
    logic          ack_q;
    logic [31:0]   dat_q, dat_d;
    logic          unused_bits;

    assign accept  = cyc_i & stb_i & ~ack_q;
    assign hit     = (adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = decode_reg(adr_i[3:0]);
    assign bus_wr  = accept & hit & we_i;
    assign bus_rd  = accept & hit & ~we_i;

    assign tx_push    = bus_wr & (reg_sel == RegData) & ~tx_full;
    assign tx_ovf_evt = bus_wr & (reg_sel == RegData) & tx_full;
    assign tx_pop     = ~tx_empty & tx_ready_i;
    assign rx_push    = rx_valid_i & ~rx_full;
    assign rx_pop     = bus_rd & (reg_sel == RegData) & ~rx_empty;
    assign rx_unf_evt = bus_rd & (reg_sel == RegData) & rx_empty;

    team_06_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (dat_i),
        .rdata (tx_data_o),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    team_06_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_rx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_data_i),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign tx_valid_o = ~tx_empty;
    assign rx_ready_o = ~rx_full;

    always_comb begin
        status                     = '0;
        status[StatTxFull]         = tx_full;
        status[StatTxEmpty]        = tx_empty;
        status[StatRxFull]         = rx_full;
        status[StatRxEmpty]        = rx_empty;
        status[StatTxCount +: 8]   = 8'(tx_count);
        status[StatRxCount +: 8]   = 8'(rx_count);
    end

`ifdef TEAM_06_BRIDGE_IRQ_EN
    logic [3:0] irq_en_q, irq_en_d;
    logic       tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d, irq_q, w1c;

    assign w1c = bus_wr & (reg_sel == RegIrqStat);

    always_comb begin
        irq_en_d = irq_en_q;
        if (bus_wr && (reg_sel == RegIrqEn) && sel_i[0]) irq_en_d = dat_i[3:0];
        // Clear is applied before the new event so a coincident event survives.
        tx_ovf_d = (tx_ovf_q & ~(w1c & dat_i[IrqTxOvf])) | tx_ovf_evt;
        rx_unf_d = (rx_unf_q & ~(w1c & dat_i[IrqRxUnf])) | rx_unf_evt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_en_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
            irq_q    <= |(irq_stat & irq_en_q);
        end
    end

    assign irq_stat    = {rx_unf_q, tx_ovf_q, tx_empty, ~rx_empty};
    assign irq_en      = irq_en_q;
    assign irq_o       = irq_q;
    assign unused_bits = ^{adr_i[1:0], sel_i[3:1]};
`else
    assign irq_stat    = '0;
    assign irq_en      = '0;
    assign irq_o       = 1'b0;
    assign unused_bits = ^{adr_i[1:0], sel_i, tx_ovf_evt, rx_unf_evt};
`endif

    always_comb begin
        dat_d = '0;
        if (bus_rd) begin
            unique case (reg_sel)
                RegData:    dat_d = rx_empty ? '0 : rx_rdata;
                RegStatus:  dat_d = status;
                RegIrqEn:   dat_d = {28'b0, irq_en};
                RegIrqStat: dat_d = {28'b0, irq_stat};
            endcase
        end
    end

    // dat_q is rewritten every cycle, so it is zero whenever no ack is presented.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= accept;
            dat_q <= dat_d;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;

endmodule

// File: tb/tb_team_06_wb_fifo_bridge.sv
// Directed self-checking bench for team_06_wb_fifo_bridge; interrupt expectations
// follow whether TEAM_06_BRIDGE_IRQ_EN is defined.
module tb_team_06_wb_fifo_bridge;
    import team_06_bridge_pkg::*;

`ifdef TEAM_06_BRIDGE_IRQ_EN
    localparam bit IrqOn = 1'b1;
`else
    localparam bit IrqOn = 1'b0;
`endif

    localparam logic [31:0] Base      = 32'h3000_0000;
    localparam logic [31:0] ADat      = Base | {28'b0, OffData};
    localparam logic [31:0] AStatus   = Base | {28'b0, OffStatus};
    localparam logic [31:0] AIrqEn    = Base | {28'b0, OffIrqEn};
    localparam logic [31:0] AIrqStat  = Base | {28'b0, OffIrqStat};

    logic        clk = 1'b0;
    logic        rst_i, cyc_i, stb_i, we_i, tx_ready_i, rx_valid_i;
    logic [31:0] adr_i, dat_i, rx_data_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_o, tx_data_o;
    logic        ack_o, irq_o, tx_valid_o, rx_ready_o;

    team_06_wb_fifo_bridge #(.BASE_ADDR(Base), .DEPTH(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .adr_i      (adr_i),
        .dat_i      (dat_i),
        .sel_i      (sel_i),
        .cyc_i      (cyc_i),
        .stb_i      (stb_i),
        .we_i       (we_i),
        .dat_o      (dat_o),
        .ack_o      (ack_o),
        .irq_o      (irq_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        ack1, ack2, irq_at_ack;
    logic [31:0] dat2, r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called one step after a rising edge; returns one step after the edge following the ack.
    task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                       output logic [31:0] rdat);
        adr_i = adr;
        we_i  = we;
        dat_i = wdat;
        sel_i = 4'hF;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        @(posedge clk); #1;
        ack1       = ack_o;
        rdat       = dat_o;
        irq_at_ack = irq_o;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        @(posedge clk); #1;
        ack2 = ack_o;
        dat2 = dat_o;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        bus(adr, 1'b1, wdat, dummy);
    endtask

    task automatic rx_push(input logic [31:0] d);
        rx_data_i  = d;
        rx_valid_i = 1'b1;
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
    endtask

    initial begin
        {cyc_i, stb_i, we_i, tx_ready_i, rx_valid_i} = '0;
        adr_i = '0; dat_i = '0; rx_data_i = '0; sel_i = '0;
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, ack_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", {31'b0, irq_o}, 32'd0);
        chk("rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
        chk("rst_rx_ready", {31'b0, rx_ready_o}, 32'd1);
        rst_i = 1'b0;

        bus(AStatus, 1'b0, 32'd0, r);
        chk("status_rst", r, 32'h0000_000A);
        chk("ack_latency", {31'b0, ack1}, 32'd1);
        chk("ack_one_cycle", {31'b0, ack2}, 32'd0);
        chk("dat_idle", dat2, 32'd0);

        // Address miss: acked, reads zero, no state change.
        wr(32'h4000_0000, 32'h55);
        chk("miss_wr_ack", {31'b0, ack1}, 32'd1);
        bus(32'h4000_0004, 1'b0, 32'd0, r);
        chk("miss_rd_dat", r, 32'd0);
        bus(AStatus, 1'b0, 32'd0, r);
        chk("miss_no_push", r, 32'h0000_000A);

        // TX overflow with a stalled consumer.
        for (int i = 0; i < 9; i++) wr(ADat, 32'h100 + i);
        bus(AStatus, 1'b0, 32'd0, r);
        chk("tx_full_status", r, 32'h0000_0809);
        chk("tx_head", tx_data_o, 32'h100);
        bus(AIrqStat, 1'b0, 32'd0, r);
        chk("tx_ovf_set", r, IrqOn ? 32'h4 : 32'h0);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tx_drain%0d", i), tx_data_o, 32'h100 + i);
            @(posedge clk); #1;
        end
        tx_ready_i = 1'b0;
        chk("tx_ninth_absent", {31'b0, tx_valid_o}, 32'd0);
        bus(AIrqStat, 1'b0, 32'd0, r);
        chk("tx_ovf_sticky", r, IrqOn ? 32'h6 : 32'h0);
        wr(AIrqStat, 32'h4);
        bus(AIrqStat, 1'b0, 32'd0, r);
        chk("tx_ovf_w1c", r, IrqOn ? 32'h2 : 32'h0);

        // RX ordering and underflow.
        rx_push(32'hDEAD_BEEF);
        rx_push(32'h1234_5678);
        bus(AStatus, 1'b0, 32'd0, r);
        chk("rx_status", r, 32'h0002_0002);
        bus(ADat, 1'b0, 32'd0, r);
        chk("rx_rd0", r, 32'hDEAD_BEEF);
        bus(ADat, 1'b0, 32'd0, r);
        chk("rx_rd1", r, 32'h1234_5678);
        bus(ADat, 1'b0, 32'd0, r);
        chk("rx_unf_dat", r, 32'd0);
        bus(AIrqStat, 1'b0, 32'd0, r);
        chk("rx_unf_set", r, IrqOn ? 32'hA : 32'h0);

        // One bus port: the W1C and the next overflow land on adjacent transactions.
        for (int i = 0; i < 8; i++) wr(ADat, 32'h200 + i);
        wr(AIrqStat, 32'hC);
        wr(ADat, 32'h2FF);
        bus(AIrqStat, 1'b0, 32'd0, r);
        chk("w1c_vs_ovf", r, IrqOn ? 32'h4 : 32'h0);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tx2_drain%0d", i), tx_data_o, 32'h200 + i);
            @(posedge clk); #1;
        end
        tx_ready_i = 1'b0;
        chk("tx2_empty", {31'b0, tx_valid_o}, 32'd0);

        // Interrupt latency on RX arrival.
        wr(AIrqEn, 32'h1);
        bus(AIrqEn, 1'b0, 32'd0, r);
        chk("irq_en_rd", r, IrqOn ? 32'h1 : 32'h0);
        chk("irq_idle", {31'b0, irq_o}, 32'd0);
        rx_push(32'hCAFE_F00D);
        chk("irq_lat0", {31'b0, irq_o}, 32'd0);
        @(posedge clk); #1;
        chk("irq_rise", {31'b0, irq_o}, {31'b0, IrqOn});
        @(posedge clk); #1;
        chk("irq_hold", {31'b0, irq_o}, {31'b0, IrqOn});
        bus(ADat, 1'b0, 32'd0, r);
        chk("irq_rd", r, 32'hCAFE_F00D);
        chk("irq_hold_rd", {31'b0, irq_at_ack}, {31'b0, IrqOn});
        chk("irq_fall", {31'b0, irq_o}, 32'd0);

        // Reset with half-full FIFOs and a request in flight.
        for (int i = 0; i < 4; i++) wr(ADat, 32'h300 + i);
        for (int i = 0; i < 4; i++) rx_push(32'h400 + i);
        bus(AStatus, 1'b0, 32'd0, r);
        chk("half_status", r, 32'h0004_0400);
        chk("irq_pre_rst", {31'b0, irq_o}, {31'b0, IrqOn});
        adr_i = AStatus; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ack", {31'b0, ack_o}, 32'd0);
        chk("rst_mid_tx", {31'b0, tx_valid_o}, 32'd0);
        chk("rst_mid_rx", {31'b0, rx_ready_o}, 32'd1);
        chk("rst_mid_irq", {31'b0, irq_o}, 32'd0);
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
        bus(AStatus, 1'b0, 32'd0, r);
        chk("rst_mid_status", r, 32'h0000_000A);
        bus(AIrqEn, 1'b0, 32'd0, r);
        chk("rst_mid_irq_en", r, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/team_06_wb_fifo_bridge.md
TEAM_06_WB_FIFO_BRIDGE -- requirements
Module: team_06_wb_fifo_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the Wishbone base address; only adr_i[31:4] is compared against it.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the entries per FIFO; it is a power of two, range 2..64.
REQ-003 SHALL use one clock and a synchronous, active-high reset (clk_i and rst_i below).
REQ-004 SHALL have port clk_i, input, 1 bit: system clock, fed from wb_clk_i.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous active-high reset, fed from wb_rst_i.
REQ-006 SHALL have ports adr_i, dat_i, sel_i, cyc_i, stb_i, we_i, all inputs, widths 32/32/4/1/1/1: Wishbone slave request.
REQ-007 SHALL have ports dat_o (output, 32 bits) and ack_o (output, 1 bit): Wishbone slave response.
REQ-008 SHALL have port irq_o, output, 1 bit: level interrupt to the management core.
REQ-009 SHALL have ports tx_data_o (output, 32 bits), tx_valid_o (output, 1 bit) and tx_ready_i (input, 1 bit): stream into the team core.
REQ-010 SHALL have ports rx_data_i (input, 32 bits), rx_valid_i (input, 1 bit) and rx_ready_o (output, 1 bit): stream out of the team core.

Function
REQ-011 SHALL accept a request in any cycle where cyc_i & stb_i & !ack_o; ack_o is driven high for exactly one cycle, in the cycle after acceptance (latency 1, no wait states).
REQ-012 SHALL decode the register from adr_i[3:2]: 0 DATA, 1 STATUS, 2 IRQ_EN, 3 IRQ_STAT.
REQ-013 SHALL, for a request whose adr_i[31:4] does not match BASE_ADDR, still acknowledge it, return dat_o = 0, and leave all state unchanged.
REQ-014 SHALL, on a DATA write, push dat_i into the TX FIFO; if the TX FIFO is full, it drops the data and sets the sticky flag IRQ_STAT[2] (tx_ovf).
REQ-015 SHALL, on a DATA read, pop the RX FIFO head onto dat_o; if the RX FIFO is empty, it returns 0 and sets the sticky flag IRQ_STAT[3] (rx_unf).
REQ-016 SHALL make STATUS read-only, laid out as: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [15:8] tx_count, [23:16] rx_count; writes to STATUS are ignored.
REQ-017 SHALL make IRQ_EN[3:0] read/write, with the write gated by sel_i[0].
REQ-018 SHALL make IRQ_STAT a write-1-to-clear register: [0] rx_nonempty (live level), [1] tx_empty (live level), [2] tx_ovf (sticky), [3] rx_unf (sticky).
REQ-019 SHALL apply the clear first when a sticky event and its W1C occur in the same cycle, so the flag ends the cycle set.
REQ-020 SHALL drive irq_o = |(IRQ_STAT & IRQ_EN), registered, so irq_o has one cycle of latency.
REQ-021 SHALL drive tx_valid_o = !tx_empty and tx_data_o = TX head; an entry is popped when tx_valid_o & tx_ready_i.
REQ-022 SHALL drive rx_ready_o = !rx_full; an entry is pushed when rx_valid_i & rx_ready_o.
REQ-023 SHALL, when a FIFO is full and a push and a pop occur in the same cycle, perform both operations; only the bus push into TX depends on the pre-cycle full flag.
REQ-024 SHALL keep FIFO pointers log2(DEPTH) bits wide with natural wrap-around; the count is log2(DEPTH)+1 bits wide, zero-extended into STATUS.
REQ-025 SHALL drive dat_o = 0 whenever ack_o is low.

Reset
REQ-026 SHALL, while rst_i is high at a clk_i edge, set: FIFOs empty, ack_o=0, dat_o=0, irq_o=0, IRQ_EN=0, sticky flags=0, tx_valid_o=0, rx_ready_o=1.
REQ-027 SHALL, when rst_i is asserted mid-transaction, abort the pending ack; the bus master retries.

Configuration
REQ-028 SHALL, with TEAM_06_BRIDGE_IRQ_EN defined, implement IRQ_EN, IRQ_STAT and irq_o as specified above.
REQ-029 SHALL, without TEAM_06_BRIDGE_IRQ_EN, tie irq_o to 0; IRQ_EN and IRQ_STAT then read 0, writes to them are ignored, and the sticky logic is removed.

Structure
REQ-030 SHALL place the register offsets, the STATUS and IRQ bit indices, and the reg_sel_e enum in the package team_06_bridge_pkg.
REQ-031 SHALL instantiate the sub-module team_06_sync_fifo (parameters DEPTH and WIDTH; ports push, pop, wdata, rdata, full, empty, count) twice, once for TX and once for RX.

Verification
REQ-032 SHALL verify: after reset, a STATUS read returns 32'h0000_000A, and ack_o pulses exactly 1 cycle after stb_i.
REQ-033 SHALL verify: with tx_ready_i=0, write DATA 9 times with DEPTH=8 -> STATUS[0]=1, tx_count=8, IRQ_STAT[2]=1, and the ninth word is absent from the FIFO.
REQ-034 SHALL verify: push rx_data_i=32'hDEAD_BEEF, then 32'h1234_5678 -> two DATA reads return those words in that order, and a third read returns 0 and sets IRQ_STAT[3].
REQ-035 SHALL verify: with IRQ_EN=4'b0001 and an RX push -> irq_o rises 1 cycle after rx_empty falls, and stays high until the RX FIFO is drained.
REQ-036 SHALL verify: a W1C write of 4'b1100 to IRQ_STAT in the same cycle as a new overflow -> tx_ovf remains 1 and rx_unf is cleared.
REQ-037 SHALL verify: asserting rst_i while the FIFOs are half-full and a request is pending -> the next cycle shows no ack, empty FIFOs and irq_o=0.
